// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and control bundle for the hazard sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
        logic exmem_en;
        logic memwb_en;
        logic memwb_bubble;
    } ctrl_t;

    // Normal flow: every stage advances, nothing squashed
    localparam ctrl_t CTRL_DEFAULT = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
        idex_bubble: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1, memwb_bubble: 1'b0
    };

    // Whole pipeline holds its contents
    localparam ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
        idex_bubble: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0, memwb_bubble: 1'b0
    };

    // Every register loads and every squash is on, so unreset registers fill with NOPs
    localparam ctrl_t CTRL_RESET = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
        idex_bubble: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1, memwb_bubble: 1'b1
    };

    function automatic logic any_hold(input ctrl_t c);
        return !(c.pc_en & c.ifid_en & c.idex_en & c.exmem_en & c.memwb_en);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    // Clear beats increment; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs_i,
    input  logic [4:0]       ID_rt_i,
    input  logic             ID_uses_rt_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rt_i,
    input  logic             br_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             cnt_clr_i,
    output logic             PC_en_o,
    output logic             IFID_en_o,
    output logic             IFID_flush_o,
    output logic             IDEX_en_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_en_o,
    output logic             MEMWB_en_o,
    output logic             MEMWB_bubble_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    import pipe_ctrl_pkg::*;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic       load_use;
    logic       mem_stall;
    logic       run_eval;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       stall_ev;
    logic       flush_ev;

    // Hazard detection; a load into $zero never creates a dependency
    always_comb begin
        load_use  = EX_MemRead_i && (EX_rt_i != REG_ZERO) &&
                    ((EX_rt_i == ID_rs_i) || (ID_uses_rt_i && (EX_rt_i == ID_rt_i)));
        mem_stall = dmem_req_i && !dmem_ready_i;
    end

    // Next state, wait counter and pipeline controls; freeze outranks load-use outranks flush
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        ctrl       = CTRL_DEFAULT;
        run_eval   = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    ctrl       = CTRL_FREEZE;
                    state_next = MEM_WAIT;
                    wait_next  = 8'd1;
                end else begin
                    run_eval  = 1'b1;
                    wait_next = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready_i) begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_next = ERROR;
                    end else begin
                        wait_next = wait_cnt + 8'd1;
                    end
                end else begin
                    run_eval   = 1'b1;
                    state_next = RUN;
                    wait_next  = 8'd0;
                end
            end
            ERROR: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                ctrl       = CTRL_FREEZE;
                state_next = RUN;
                wait_next  = 8'd0;
            end
        endcase
        // A branch that depends on the load in EX is held back, not flushed
        if (run_eval) begin
            if (load_use) begin
                ctrl.pc_en       = 1'b0;
                ctrl.ifid_en     = 1'b0;
                ctrl.idex_bubble = 1'b1;
            end else if (br_taken_i || jump_i) begin
                ctrl.ifid_flush = 1'b1;
            end
        end
    end

    // Reset overrides the controls so the datapath fills with NOPs
    always_comb begin
        ctrl_out = ctrl;
        if (rst_i) begin
            ctrl_out = CTRL_RESET;
        end
    end

    // Event qualifiers for the debug counters
    always_comb begin
        stall_ev = !rst_i && (state != ERROR) && any_hold(ctrl);
        flush_ev = !rst_i && ctrl.ifid_flush;
    end

    // State and wait-counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (cnt_clr_i),
        .inc   (stall_ev),
        .value (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (cnt_clr_i),
        .inc   (flush_ev),
        .value (flush_cnt_o)
    );

    assign PC_en_o        = ctrl_out.pc_en;
    assign IFID_en_o      = ctrl_out.ifid_en;
    assign IFID_flush_o   = ctrl_out.ifid_flush;
    assign IDEX_en_o      = ctrl_out.idex_en;
    assign IDEX_bubble_o  = ctrl_out.idex_bubble;
    assign EXMEM_en_o     = ctrl_out.exmem_en;
    assign MEMWB_en_o     = ctrl_out.memwb_en;
    assign MEMWB_bubble_o = ctrl_out.memwb_bubble;
    assign err_o          = (state == ERROR);
    assign state_o        = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;

    localparam int MAXW = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [4:0]    ID_rs_i;
    logic [4:0]    ID_rt_i;
    logic          ID_uses_rt_i;
    logic          EX_MemRead_i;
    logic [4:0]    EX_rt_i;
    logic          br_taken_i;
    logic          jump_i;
    logic          dmem_req_i;
    logic          dmem_ready_i;
    logic          cnt_clr_i;
    logic          PC_en_o;
    logic          IFID_en_o;
    logic          IFID_flush_o;
    logic          IDEX_en_o;
    logic          IDEX_bubble_o;
    logic          EXMEM_en_o;
    logic          MEMWB_en_o;
    logic          MEMWB_bubble_o;
    logic          err_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: error flag, consecutive frozen cycles of the current access, counters
    bit m_err    = 1'b0;
    int m_frozen = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ID_rs_i        (ID_rs_i),
        .ID_rt_i        (ID_rt_i),
        .ID_uses_rt_i   (ID_uses_rt_i),
        .EX_MemRead_i   (EX_MemRead_i),
        .EX_rt_i        (EX_rt_i),
        .br_taken_i     (br_taken_i),
        .jump_i         (jump_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ready_i   (dmem_ready_i),
        .cnt_clr_i      (cnt_clr_i),
        .PC_en_o        (PC_en_o),
        .IFID_en_o      (IFID_en_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_en_o      (IDEX_en_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .EXMEM_en_o     (EXMEM_en_o),
        .MEMWB_en_o     (MEMWB_en_o),
        .MEMWB_bubble_o (MEMWB_bubble_o),
        .err_o          (err_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en, MEMWB_bubble}
    function automatic logic [7:0] obs_ctrl();
        return {PC_en_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o,
                EXMEM_en_o, MEMWB_en_o, MEMWB_bubble_o};
    endfunction

    function automatic bit m_mem_block();
        if (m_frozen > 0) return !dmem_ready_i;
        return dmem_req_i && !dmem_ready_i;
    endfunction

    function automatic bit m_load_use();
        if (!EX_MemRead_i || EX_rt_i == 5'd0) return 1'b0;
        return (EX_rt_i == ID_rs_i) || (ID_uses_rt_i && EX_rt_i == ID_rt_i);
    endfunction

    function automatic logic [7:0] m_ctrl();
        if (rst_i)          return 8'b1111_1111;
        if (m_err)          return 8'b0000_0000;
        if (m_mem_block())  return 8'b0000_0000;
        if (m_load_use())   return 8'b0001_1110;
        if (br_taken_i || jump_i) return 8'b1111_0110;
        return 8'b1101_0110;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input int rs, input int rt, input bit uses_rt,
                         input bit memrd, input int exrt, input bit br, input bit jmp,
                         input bit req, input bit rdy, input bit clr);
        rst_i        = rst;
        ID_rs_i      = 5'(rs);
        ID_rt_i      = 5'(rt);
        ID_uses_rt_i = uses_rt;
        EX_MemRead_i = memrd;
        EX_rt_i      = 5'(exrt);
        br_taken_i   = br;
        jump_i       = jmp;
        dmem_req_i   = req;
        dmem_ready_i = rdy;
        cnt_clr_i    = clr;
    endtask

    // Compare all outputs mid-cycle, then clock once and advance the model
    task automatic step(input string tag);
        logic [7:0] exp;
        bit stalled;
        #1;
        exp = m_ctrl();
        check({tag, ".ctrl"},  16'(obs_ctrl()), 16'(exp));
        check({tag, ".state"}, 16'(state_o), m_err ? 16'd2 : (m_frozen > 0 ? 16'd1 : 16'd0));
        check({tag, ".err"},   16'(err_o), 16'(m_err));
        check({tag, ".stall"}, 16'(stall_cnt_o), 16'(m_stall));
        check({tag, ".flush"}, 16'(flush_cnt_o), 16'(m_flush));
        @(posedge clk_i);
        if (rst_i) begin
            m_err = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
        end else begin
            stalled = !m_err && !(exp[7] && exp[6] && exp[4] && exp[2] && exp[1]);
            if (cnt_clr_i) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (stalled && m_stall < CMAX) m_stall++;
                if (exp[5] && m_flush < CMAX) m_flush++;
            end
            if (!m_err) begin
                if (m_mem_block()) begin
                    m_frozen++;
                    if (m_frozen > MAXW) m_err = 1;
                end else begin
                    m_frozen = 0;
                end
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        step("reset");

        drive(0, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0);  step("lu_rs");
        drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);  step("idle1");
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);  step("lu_zero");
        drive(0, 3, 9, 1, 1, 9, 0, 0, 0, 0, 0);  step("lu_rt");
        drive(0, 3, 9, 0, 1, 9, 0, 0, 0, 0, 0);  step("no_rt_use");

        drive(0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0);  step("branch");
        drive(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);  step("jump");
        drive(0, 8, 0, 0, 1, 8, 1, 0, 0, 0, 0);  step("lu_br");

        for (int i = 0; i < 3; i++) begin
            drive(0, 8, 0, 0, 1, 8, 1, 0, 1, 0, 0);  step("memwait");
        end
        drive(0, 1, 2, 0, 0, 0, 1, 0, 1, 1, 0);  step("mem_resume");
        drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);  step("idle2");

        for (int i = 0; i < MAXW + 1; i++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);  step("timeout");
        end
        drive(0, 1, 2, 0, 0, 0, 1, 0, 1, 1, 0);  step("err_hold");
        drive(0, 1, 2, 0, 1, 1, 0, 0, 0, 1, 0);  step("err_hold2");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("err_reset");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("after_reset");

        for (int i = 0; i < 20; i++) begin
            drive(0, 5, 0, 0, 1, 5, 1, 0, 0, 0, 0);  step("sat");
        end
        drive(0, 5, 0, 0, 1, 5, 0, 0, 0, 0, 1);  step("clr_stall");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("after_clr");

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom),
                  $urandom_range(0, 29) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It covers load-use hazards, taken branch/jump flushes, and multi-cycle data-memory waits with a timeout. It also keeps saturating stall/flush event counters for debug.

Parameters:
MAX_WAIT, 16, MEM_WAIT cycles before entering ERROR (range 1..255)
CNT_W, 16, width of the stall and flush counters

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
ID_rs_i  in  5  rs field of the instruction in ID
ID_rt_i  in  5  rt field of the instruction in ID
ID_uses_rt_i  in  1  instruction in ID reads rt
EX_MemRead_i  in  1  instruction in EX is a load
EX_rt_i  in  5  destination of the load in EX
br_taken_i  in  1  branch resolved taken in ID
jump_i  in  1  jump decoded in ID
dmem_req_i  in  1  MEM stage is accessing data memory
dmem_ready_i  in  1  data memory completes the access this cycle
cnt_clr_i  in  1  synchronous clear of both counters
PC_en_o  out  1  PC update enable
IFID_en_o  out  1  IF/ID load enable
IFID_flush_o  out  1  IF/ID loads a NOP
IDEX_en_o  out  1  ID/EX load enable
IDEX_bubble_o  out  1  ID/EX loads zeroed control fields
EXMEM_en_o  out  1  EX/MEM load enable
MEMWB_en_o  out  1  MEM/WB load enable
MEMWB_bubble_o  out  1  MEM/WB loads RegWrite=0
err_o  out  1  memory timeout; sticky until reset
state_o  out  2  0=RUN 1=MEM_WAIT 2=ERROR
stall_cnt_o  out  CNT_W  stall cycles, saturating
flush_cnt_o  out  CNT_W  IF/ID flushes, saturating

Behaviour:
- Reset (rst_i=1 during a clock edge): state=RUN, wait counter=0, err_o=0, both counters=0.
- While rst_i=1, outputs are forced: all *_en_o=1, IFID_flush_o=1, IDEX_bubble_o=1, MEMWB_bubble_o=1. Pipeline registers without reset therefore fill with NOPs.
- Definitions:
  - lu = EX_MemRead_i & (EX_rt_i!=0) & (EX_rt_i==ID_rs_i | (ID_uses_rt_i & EX_rt_i==ID_rt_i)).
  - ms = dmem_req_i & ~dmem_ready_i.
- Outputs are combinational from state and inputs, with zero-cycle latency. Defaults: all en=1, flush=0, bubbles=0.
- Priority order is ERROR > freeze > lu > flush.
- RUN:
  - ms=1: all en=0 (freeze), next=MEM_WAIT, wait counter=1.
  - Else lu=1: PC_en_o=0, IFID_en_o=0, IDEX_bubble_o=1. br_taken_i and jump_i are ignored this cycle, because the branch operand is not ready.
  - Else (br_taken_i|jump_i)=1: IFID_flush_o=1.
- MEM_WAIT:
  - dmem_ready_i=0: all en=0. The wait counter increments. If the counter equals MAX_WAIT, next=ERROR.
  - dmem_ready_i=1: outputs evaluate as in RUN with ms=0 (lu/flush apply the same cycle), next=RUN.
- ERROR: all en=0, err_o=1. Exit only via rst_i.
- Flush during freeze is not latched. The branch stays frozen in ID and reasserts br_taken_i after resume.
- stall_cnt increments each cycle with any en=0 in RUN/MEM_WAIT (freeze or lu). It does not count in ERROR or reset.
- flush_cnt increments each cycle IFID_flush_o=1 outside reset.
- Both counters saturate at all-ones. cnt_clr_i has priority over increment.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding constants RUN/MEM_WAIT/ERROR;
  - control-bundle typedef (en/flush/bubble fields);
  - REG_ZERO=5'd0.
- Sub-module sat_counter (width param, clr, inc, value) is instantiated twice for the stall and flush counters.

Test Plan:
- Reset: rst_i=1 for 2 cycles -> IFID_flush_o=1, IDEX_bubble_o=1, all en=1, counters=0, state_o=0.
- Load-use: EX_MemRead_i=1, EX_rt_i=8, ID_rs_i=8 -> PC_en_o=0, IFID_en_o=0, IDEX_bubble_o=1 for 1 cycle, stall_cnt_o=1. Repeat with EX_rt_i=0 -> no stall.
- Branch: br_taken_i=1, no hazard -> IFID_flush_o=1 for 1 cycle, flush_cnt_o=1. With lu=1 and br_taken_i=1 in the same cycle -> stall only, no flush.
- Memory wait: dmem_req_i=1, ready low 3 cycles then high -> all en=0 for 3 cycles, state_o=1, resume on the ready cycle, stall_cnt_o=3.
- Timeout: MAX_WAIT=4, ready held low -> state_o=2, err_o=1 after 4 MEM_WAIT cycles. Later ready=1 -> remains ERROR. rst_i clears it.
- Saturation: CNT_W=4, 20 load-use cycles -> stall_cnt_o=15. cnt_clr_i with a simultaneous stall -> 0.
